// File: rtl/router_pkg.sv
// Shared constants, state encoding and Moore output decode for the 1x3 router controller.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t LOAD_FIRST_DATA    = 3'd1;
    localparam state_t LOAD_DATA          = 3'd2;
    localparam state_t LOAD_PARITY        = 3'd3;
    localparam state_t FIFO_FULL_STATE    = 3'd4;
    localparam state_t LOAD_AFTER_FULL    = 3'd5;
    localparam state_t WAIT_TILL_EMPTY    = 3'd6;
    localparam state_t CHECK_PARITY_ERROR = 3'd7;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic write_enb_reg;
        logic rst_int_reg;
        logic busy;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = 8'b1000_0000;

    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = 8'b0000_0000;
        case (st)
            DECODE_ADDRESS:     c.detect_add = 1'b1;
            LOAD_FIRST_DATA:    begin c.lfd_state = 1'b1; c.busy = 1'b1; end
            LOAD_DATA:          begin c.ld_state = 1'b1; c.write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin c.write_enb_reg = 1'b1; c.busy = 1'b1; end
            FIFO_FULL_STATE:    begin c.full_state = 1'b1; c.busy = 1'b1; end
            LOAD_AFTER_FULL:    begin c.laf_state = 1'b1; c.write_enb_reg = 1'b1; c.busy = 1'b1; end
            WAIT_TILL_EMPTY:    c.busy = 1'b1;
            CHECK_PARITY_ERROR: begin c.rst_int_reg = 1'b1; c.busy = 1'b1; end
            default:            c = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-level controller of the 1x3 router: header decode, payload/parity sequencing,
// full-FIFO stalling and soft-reset abort. Outputs are flopped copies of the state decode.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [NUM_PORTS-1:0] empty_s;
    logic [NUM_PORTS-1:0] srst_s;
    logic                hdr_empty_s;
    logic                sel_empty_s;
    logic                sel_srst_s;
    logic                hdr_valid_s;

    assign empty_s     = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_s      = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_valid_s = pkt_valid && (data_in != INVALID_ADDR);

    // Select the empty flag of the port named by the incoming header.
    always_comb begin
        hdr_empty_s = 1'b0;
        case (data_in)
            2'd0:    hdr_empty_s = empty_s[0];
            2'd1:    hdr_empty_s = empty_s[1];
            2'd2:    hdr_empty_s = empty_s[2];
            default: hdr_empty_s = 1'b0;
        endcase
    end

    // Select empty and soft-reset flags of the latched destination; invalid address selects nothing.
    always_comb begin
        sel_empty_s = 1'b0;
        sel_srst_s  = 1'b0;
        case (addr_q)
            2'd0:    begin sel_empty_s = empty_s[0]; sel_srst_s = srst_s[0]; end
            2'd1:    begin sel_empty_s = empty_s[1]; sel_srst_s = srst_s[1]; end
            2'd2:    begin sel_empty_s = empty_s[2]; sel_srst_s = srst_s[2]; end
            default: begin sel_empty_s = 1'b0;       sel_srst_s = 1'b0;       end
        endcase
    end

    // Next-state logic; a soft reset of the addressed port overrides every other transition.
    always_comb begin
        state_d = state_q;
        if ((state_q != DECODE_ADDRESS) && sel_srst_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_valid_s && hdr_empty_s) state_d = LOAD_FIRST_DATA;
                    else if (hdr_valid_s)           state_d = WAIT_TILL_EMPTY;
                    else                            state_d = DECODE_ADDRESS;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                    else                 state_d = LOAD_DATA;
                end
                FIFO_FULL_STATE: begin
                    if (fifo_full) state_d = FIFO_FULL_STATE;
                    else           state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (fifo_full) state_d = FIFO_FULL_STATE;
                    else           state_d = DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel_empty_s) state_d = LOAD_FIRST_DATA;
                    else             state_d = WAIT_TILL_EMPTY;
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // Address latch follows the source bus while a header is offered in decode.
    always_comb begin
        if ((state_q == DECODE_ADDRESS) && pkt_valid) addr_d = data_in;
        else                                           addr_d = addr_q;
    end

    // Decoding from state_d lets the output flops track the state register cycle for cycle.
    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    // State, address and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign detect_add    = ctrl_q.detect_add;
    assign lfd_state     = ctrl_q.lfd_state;
    assign ld_state      = ctrl_q.ld_state;
    assign laf_state     = ctrl_q.laf_state;
    assign full_state    = ctrl_q.full_state;
    assign write_enb_reg = ctrl_q.write_enb_reg;
    assign rst_int_reg   = ctrl_q.rst_int_reg;
    assign busy          = ctrl_q.busy;

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-level controller for the 1x3 router.
- Decodes the header address and sequences header, payload and parity loading into the register block.
- Stalls the source (busy) while a destination FIFO is full or still draining.
- Drives write_enb_reg and detect_add into the synchroniser, and reacts to its fifo_full and soft_reset outputs.
- Pure control block: no datapath storage except a 2-bit latched destination address.

Parameters:
ADDR_W, 2, width of header address field; fixed by the 3-port router, not to be overridden
NUM_PORTS, 3, number of destination FIFOs; address 2'b11 is invalid

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source asserts for the header and all payload bytes; deasserts on the parity byte
data_in  in  2  header address bits [1:0] from the source bus
fifo_full  in  1  full flag of the currently addressed FIFO (from the synchroniser)
fifo_empty_0  in  1  FIFO 0 empty
fifo_empty_1  in  1  FIFO 1 empty
fifo_empty_2  in  1  FIFO 2 empty
soft_reset_0  in  1  FIFO 0 read-timeout soft reset
soft_reset_1  in  1  FIFO 1 read-timeout soft reset
soft_reset_2  in  1  FIFO 2 read-timeout soft reset
parity_done  in  1  register block has written the parity byte
low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
detect_add  out  1  header decode phase; synchroniser latches the address
lfd_state  out  1  load-first-data (header) cycle
ld_state  out  1  payload load
laf_state  out  1  load-after-full (flush of the held byte)
full_state  out  1  stalled on full FIFO
write_enb_reg  out  1  register block writes to the FIFO this cycle
rst_int_reg  out  1  parity check cycle; clears internal register flags
busy  out  1  source must hold data_in

Behaviour:
State register:
- 3-bit state, encoded from the package.
- Asynchronous clear to DECODE_ADDRESS when resetn=0.
- addr_q (2 bits) cleared to 0 on reset.
- addr_q loads data_in on the rising edge when state==DECODE_ADDRESS and pkt_valid=1.
- Outputs are Moore, decoded from state only; no output latency beyond the state register.

Reset values:
- detect_add=1.
- All other outputs = 0, busy included.

Output decode:
- detect_add = DECODE_ADDRESS
- lfd_state = LOAD_FIRST_DATA
- ld_state = LOAD_DATA
- laf_state = LOAD_AFTER_FULL
- full_state = FIFO_FULL_STATE
- rst_int_reg = CHECK_PARITY_ERROR
- write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
- busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA

Transitions (evaluated each clock):
- DECODE_ADDRESS:
  - pkt_valid=1, data_in=k (k<3), fifo_empty_k=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in=k (k<3), fifo_empty_k=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay; addr_q still loads on pkt_valid=1.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE (priority).
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - else low_pkt_valid=1 -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty_[addr_q]=1 -> LOAD_FIRST_DATA; else stay.

Soft reset:
- In any state other than DECODE_ADDRESS, soft_reset_[addr_q]=1 forces DECODE_ADDRESS next cycle.
- This overrides every other transition, including when it coincides with fifo_full or parity_done.
- Soft resets of non-addressed ports are ignored.

Other boundary rules:
- Reset mid-packet aborts immediately (asynchronous); no partial write_enb_reg after resetn falls.
- No combinational path from inputs to outputs.

Decomposition:
- Package router_pkg holds:
  - state enum: DECODE_ADDRESS=0, LOAD_FIRST_DATA=1, LOAD_DATA=2, LOAD_PARITY=3, FIFO_FULL_STATE=4, LOAD_AFTER_FULL=5, WAIT_TILL_EMPTY=6, CHECK_PARITY_ERROR=7.
  - ADDR_W and NUM_PORTS constants.
  - INVALID_ADDR=2'b11.
- Single module, no sub-module: the address latch and state register are small enough to stay inline.

Test Plan:
1. Reset: resetn=0 mid-LOAD_DATA -> state DECODE_ADDRESS asynchronously; detect_add=1, busy=0, write_enb_reg=0.
2. Normal packet: data_in=1, pkt_valid=1, fifo_empty_1=1 -> LFD 1 cycle, LOAD_DATA while pkt_valid=1; on pkt_valid=0 -> LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE_ADDRESS; write_enb_reg=1 in LOAD_DATA and LOAD_PARITY only.
3. Busy destination: data_in=2 with fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1; when fifo_empty_2 goes to 1 -> LOAD_FIRST_DATA next cycle.
4. Full stall: fifo_full=1 in LOAD_DATA -> FIFO_FULL_STATE, busy=1, write_enb_reg=0. Then:
   - fifo_full=0 -> LAF.
   - parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
   - Repeat with low_pkt_valid=0 -> LOAD_DATA.
   - Repeat with parity_done=1 -> DECODE_ADDRESS.
5. Soft reset abort: addr_q=0, in WAIT_TILL_EMPTY assert soft_reset_0=1 -> DECODE_ADDRESS next cycle. Asserting soft_reset_1 instead -> no effect.
6. Invalid address: data_in=3, pkt_valid=1 for 5 cycles -> stays DECODE_ADDRESS, write_enb_reg=0 throughout.
